mem_bus_arbiter: RTL and testbench

- Shares one single-ported memory bus between the instruction-fetch stage (read-only) and the mem stage (read/write).
- Sequences each access as a multi-cycle transaction: grant, wait for slave ack, respond.
- Raises per-stage stall requests to the pipeline ctrl block while a stage's access is outstanding.
- Includes a timeout so that a dead slave cannot hang the pipeline.

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and constants for the fetch/mem bus arbiter.
// The response-data helper lives here so that every user agrees on what a write returns.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [3:0]  BUS_SEL_ALL   = 4'hF;

  // A completed write carries no load data back to the pipeline.
  function automatic logic [31:0] resp_data(input logic we, input logic [31:0] rdata);
    return (we == WRITE_ENABLE) ? ZERO_WORD : rdata;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and the mem stage.
// Each access runs IDLE -> BUSY (wait for ack or timeout) -> RESP (one-cycle ack), then back to IDLE.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       r_state;
  arb_owner_t       r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [3:0]       r_bus_sel;
  logic [31:0]      r_bus_wdata;
  logic [31:0]      r_if_rdata;
  logic [31:0]      r_mem_rdata;
  logic             r_bus_err;

  arb_state_t       w_state_next;
  arb_owner_t       w_owner_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_bus_we_next;
  logic [31:0]      w_bus_addr_next;
  logic [3:0]       w_bus_sel_next;
  logic [31:0]      w_bus_wdata_next;
  logic [31:0]      w_if_rdata_next;
  logic [31:0]      w_mem_rdata_next;
  logic             w_bus_err_next;
  logic [31:0]      w_resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state     <= ARB_IDLE;
      r_owner     <= OWN_IF;
      r_cnt       <= '0;
      r_bus_we    <= WRITE_DISABLE;
      r_bus_addr  <= ZERO_WORD;
      r_bus_sel   <= 4'h0;
      r_bus_wdata <= ZERO_WORD;
      r_if_rdata  <= ZERO_WORD;
      r_mem_rdata <= ZERO_WORD;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_owner     <= w_owner_next;
      r_cnt       <= w_cnt_next;
      r_bus_we    <= w_bus_we_next;
      r_bus_addr  <= w_bus_addr_next;
      r_bus_sel   <= w_bus_sel_next;
      r_bus_wdata <= w_bus_wdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_mem_rdata <= w_mem_rdata_next;
      r_bus_err   <= w_bus_err_next;
    end
  end

  assign w_resp_data = resp_data(r_bus_we, bus_rdata);

  always_comb begin
    w_state_next     = r_state;
    w_owner_next     = r_owner;
    w_cnt_next       = r_cnt;
    w_bus_we_next    = r_bus_we;
    w_bus_addr_next  = r_bus_addr;
    w_bus_sel_next   = r_bus_sel;
    w_bus_wdata_next = r_bus_wdata;
    w_if_rdata_next  = r_if_rdata;
    w_mem_rdata_next = r_mem_rdata;
    w_bus_err_next   = 1'b0;

    unique case (r_state)
      ARB_IDLE: begin
        // MEM wins ties: it carries the older instruction in the pipeline.
        if (mem_req) begin
          w_owner_next     = OWN_MEM;
          w_bus_we_next    = mem_we;
          w_bus_addr_next  = mem_addr;
          w_bus_sel_next   = mem_sel;
          w_bus_wdata_next = mem_wdata;
          w_cnt_next       = '0;
          w_state_next     = ARB_BUSY;
        end else if (if_req) begin
          w_owner_next     = OWN_IF;
          w_bus_we_next    = WRITE_DISABLE;
          w_bus_addr_next  = if_addr;
          w_bus_sel_next   = BUS_SEL_ALL;
          w_bus_wdata_next = ZERO_WORD;
          w_cnt_next       = '0;
          w_state_next     = ARB_BUSY;
        end
      end

      ARB_BUSY: begin
        w_cnt_next = r_cnt + 1'b1;
        // An ack on the final allowed cycle still counts as success.
        if (bus_ack) begin
          if (r_owner == OWN_MEM) w_mem_rdata_next = w_resp_data;
          else                    w_if_rdata_next  = w_resp_data;
          w_state_next = ARB_RESP;
        end else if (r_cnt == CNT_LAST) begin
          if (r_owner == OWN_MEM) w_mem_rdata_next = ZERO_WORD;
          else                    w_if_rdata_next  = ZERO_WORD;
          w_bus_err_next = 1'b1;
          w_state_next   = ARB_RESP;
        end
      end

      ARB_RESP: begin
        // Always pass through IDLE so a requester still holding its old req is not re-granted.
        w_if_rdata_next  = ZERO_WORD;
        w_mem_rdata_next = ZERO_WORD;
        w_state_next     = ARB_IDLE;
      end

      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  assign bus_req      = (r_state == ARB_BUSY);
  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_sel      = r_bus_sel;
  assign bus_wdata    = r_bus_wdata;
  assign bus_err      = r_bus_err;
  assign if_ack       = (r_state == ARB_RESP) && (r_owner == OWN_IF);
  assign mem_ack      = (r_state == ARB_RESP) && (r_owner == OWN_MEM);
  assign if_rdata     = r_if_rdata;
  assign mem_rdata    = r_mem_rdata;
  assign stallreq_if  = if_req & ~if_ack;
  assign stallreq_mem = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: each task drives one scenario cycle by cycle
// and compares outputs against hand-computed values one tick after each rising edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;

  mem_bus_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_sel = '0; mem_wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req got=%0h exp=0", bus_req); end
    n_cmp++; if ({bus_we, bus_addr, bus_sel, bus_wdata} !== 69'd0) begin n_err++; $display("FAIL reset_bus_fields got=%0h exp=0", {bus_we, bus_addr, bus_sel, bus_wdata}); end
    n_cmp++; if ({if_ack, mem_ack, bus_err} !== 3'b000) begin n_err++; $display("FAIL reset_acks got=%b exp=000", {if_ack, mem_ack, bus_err}); end
    n_cmp++; if ({if_rdata, mem_rdata} !== 64'd0) begin n_err++; $display("FAIL reset_rdata got=%0h exp=0", {if_rdata, mem_rdata}); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_release_idle got=%0h exp=0", bus_req); end
  endtask

  task automatic test_if_only;
    // cycle 0: request in IDLE
    if_req = 1'b1; if_addr = 32'h0000_0010;
    #1;
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL if_only_stall_c0 got=%0h exp=1", stallreq_if); end
    tick(); // cycle 1
    n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL if_only_bus_req_c1 got=%0h exp=1", bus_req); end
    n_cmp++; if ({bus_we, bus_addr, bus_sel, bus_wdata} !== {1'b0, 32'h10, 4'hF, 32'h0}) begin n_err++; $display("FAIL if_only_bus_fields got=%0h exp=%0h", {bus_we, bus_addr, bus_sel, bus_wdata}, {1'b0, 32'h10, 4'hF, 32'h0}); end
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL if_only_stall_c1 got=%0h exp=1", stallreq_if); end
    bus_ack = 1'b1; bus_rdata = 32'h3401_1100;
    tick(); // cycle 2
    bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL if_only_bus_req_c2 got=%0h exp=0", bus_req); end
    n_cmp++; if ({if_ack, mem_ack} !== 2'b10) begin n_err++; $display("FAIL if_only_ack_c2 got=%b exp=10", {if_ack, mem_ack}); end
    n_cmp++; if (if_rdata !== 32'h3401_1100) begin n_err++; $display("FAIL if_only_rdata got=%0h exp=34011100", if_rdata); end
    n_cmp++; if (stallreq_if !== 1'b0) begin n_err++; $display("FAIL if_only_stall_c2 got=%0h exp=0", stallreq_if); end
    tick(); // cycle 3
    if_req = 1'b0;
    n_cmp++; if ({if_ack, if_rdata} !== 33'd0) begin n_err++; $display("FAIL if_only_c3_clear got=%0h exp=0", {if_ack, if_rdata}); end
    idle_inputs();
  endtask

  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h0000_0020;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_sel = 4'b0011; mem_wdata = 32'hAABB;
    tick(); // cycle 1: MEM owns the bus
    n_cmp++; if ({bus_req, bus_we, bus_sel} !== 6'b1_1_0011) begin n_err++; $display("FAIL simul_mem_first got=%b exp=110011", {bus_req, bus_we, bus_sel}); end
    n_cmp++; if ({bus_addr, bus_wdata} !== {32'h100, 32'hAABB}) begin n_err++; $display("FAIL simul_mem_addr_data got=%0h exp=%0h", {bus_addr, bus_wdata}, {32'h100, 32'hAABB}); end
    n_cmp++; if ({stallreq_if, stallreq_mem} !== 2'b11) begin n_err++; $display("FAIL simul_stall_c1 got=%b exp=11", {stallreq_if, stallreq_mem}); end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick(); // cycle 2: RESP for MEM, write returns zero
    bus_ack = 1'b0;
    n_cmp++; if ({mem_ack, if_ack, bus_req} !== 3'b100) begin n_err++; $display("FAIL simul_mem_ack got=%b exp=100", {mem_ack, if_ack, bus_req}); end
    n_cmp++; if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL simul_mem_rdata got=%0h exp=0", mem_rdata); end
    n_cmp++; if ({stallreq_if, stallreq_mem} !== 2'b10) begin n_err++; $display("FAIL simul_stall_c2 got=%b exp=10", {stallreq_if, stallreq_mem}); end
    tick(); // cycle 3: IDLE, IF sampled
    mem_req = 1'b0; mem_we = 1'b0;
    n_cmp++; if ({bus_req, mem_ack, if_ack} !== 3'b000) begin n_err++; $display("FAIL simul_idle_c3 got=%b exp=000", {bus_req, mem_ack, if_ack}); end
    #1;
    n_cmp++; if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL simul_stall_if_c3 got=%0h exp=1", stallreq_if); end
    tick(); // cycle 4: IF on the bus
    n_cmp++; if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b0, 4'hF, 32'h20, 32'h0}) begin n_err++; $display("FAIL simul_if_grant got=%0h exp=%0h", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, {1'b1, 1'b0, 4'hF, 32'h20, 32'h0}); end
    bus_ack = 1'b1; bus_rdata = 32'h0000_CAFE;
    tick(); // cycle 5
    bus_ack = 1'b0;
    n_cmp++; if ({if_ack, mem_ack} !== 2'b10) begin n_err++; $display("FAIL simul_if_ack got=%b exp=10", {if_ack, mem_ack}); end
    n_cmp++; if (if_rdata !== 32'h0000_CAFE) begin n_err++; $display("FAIL simul_if_rdata got=%0h exp=cafe", if_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_slow_slave;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_sel = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++; if ({bus_req, mem_ack} !== 2'b10) begin n_err++; $display("FAIL slow_busy_c%0d got=%b exp=10", i, {bus_req, mem_ack}); end
      if (i == 5) begin bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF; end
    end
    tick(); // cycle 6
    bus_ack = 1'b0; bus_rdata = '0;
    n_cmp++; if ({bus_req, mem_ack, bus_err} !== 3'b010) begin n_err++; $display("FAIL slow_resp got=%b exp=010", {bus_req, mem_ack, bus_err}); end
    n_cmp++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL slow_rdata got=%0h exp=deadbeef", mem_rdata); end
    tick(); // cycle 7
    mem_req = 1'b0;
    n_cmp++; if ({mem_ack, mem_rdata} !== 33'd0) begin n_err++; $display("FAIL slow_clear got=%0h exp=0", {mem_ack, mem_rdata}); end
    idle_inputs();
  endtask

  task automatic test_timeout(input logic late_ack);
    if_req = 1'b1; if_addr = 32'h40;
    bus_rdata = 32'h5555_AAAA;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n_cmp++; if ({bus_req, if_ack, bus_err} !== 3'b100) begin n_err++; $display("FAIL timeout%0d_busy_c%0d got=%b exp=100", late_ack, i, {bus_req, if_ack, bus_err}); end
      if (i == 16 && late_ack) bus_ack = 1'b1;
    end
    tick(); // cycle 17
    bus_ack = 1'b0;
    n_cmp++; if ({bus_req, if_ack} !== 2'b01) begin n_err++; $display("FAIL timeout%0d_ack got=%b exp=01", late_ack, {bus_req, if_ack}); end
    n_cmp++; if (bus_err !== ~late_ack) begin n_err++; $display("FAIL timeout%0d_bus_err got=%0h exp=%0h", late_ack, bus_err, ~late_ack); end
    n_cmp++; if (if_rdata !== (late_ack ? 32'h5555_AAAA : 32'h0)) begin n_err++; $display("FAIL timeout%0d_rdata got=%0h exp=%0h", late_ack, if_rdata, (late_ack ? 32'h5555_AAAA : 32'h0)); end
    tick(); // cycle 18: IDLE
    if_req = 1'b0;
    n_cmp++; if ({bus_req, if_ack, bus_err} !== 3'b000) begin n_err++; $display("FAIL timeout%0d_idle got=%b exp=000", late_ack, {bus_req, if_ack, bus_err}); end
    tick();
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL timeout%0d_no_regrant got=%0h exp=0", late_ack, bus_req); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_sel = 4'hF;
    tick(); tick(); tick(); // cycle 3 of the mem transaction
    n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL rstmid_busy got=%0h exp=1", bus_req); end
    #2;
    rst = 1'b1;
    #1; // no clock edge yet
    n_cmp++; if ({bus_req, mem_ack, if_ack, bus_err} !== 4'b0000) begin n_err++; $display("FAIL rstmid_async_drop got=%b exp=0000", {bus_req, mem_ack, if_ack, bus_err}); end
    n_cmp++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_bus_addr got=%0h exp=0", bus_addr); end
    mem_req = 1'b0;
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    rst = 1'b0;
    tick();
    // spurious ack while IDLE
    bus_ack = 1'b1; bus_rdata = 32'h0000_0777;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if ({bus_req, if_ack, mem_ack} !== 3'b000) begin n_err++; $display("FAIL spurious_ack got=%b exp=000", {bus_req, if_ack, mem_ack}); end
    tick();
    n_cmp++; if ({if_ack, mem_ack, if_rdata, mem_rdata} !== 66'd0) begin n_err++; $display("FAIL spurious_ack_later got=%0h exp=0", {if_ack, mem_ack, if_rdata, mem_rdata}); end
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h44}) begin n_err++; $display("FAIL rstmid_after_grant got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'h44}); end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    n_cmp++; if ({if_ack, if_rdata} !== {1'b1, 32'h0BAD_F00D}) begin n_err++; $display("FAIL rstmid_after_ack got=%0h exp=%0h", {if_ack, if_rdata}, {1'b1, 32'h0BAD_F00D}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    int acks;
    acks = 0;
    if_req = 1'b1; if_addr = 32'h80;
    tick(); // c1
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h80}) begin n_err++; $display("FAIL b2b_grant1 got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'h80}); end
    bus_ack = 1'b1; bus_rdata = 32'h11;
    tick(); // c2 RESP, old req still held
    bus_ack = 1'b0;
    if (if_ack) acks++;
    n_cmp++; if (if_rdata !== 32'h11) begin n_err++; $display("FAIL b2b_rdata1 got=%0h exp=11", if_rdata); end
    tick(); // c3 IDLE, new request presented
    if_addr = 32'h84;
    if (if_ack) acks++;
    n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL b2b_no_dup_grant got=%0h exp=0", bus_req); end
    tick(); // c4
    if (if_ack) acks++;
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h84}) begin n_err++; $display("FAIL b2b_grant2 got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'h84}); end
    bus_ack = 1'b1; bus_rdata = 32'h22;
    tick(); // c5
    bus_ack = 1'b0;
    if (if_ack) acks++;
    n_cmp++; if (if_rdata !== 32'h22) begin n_err++; $display("FAIL b2b_rdata2 got=%0h exp=22", if_rdata); end
    tick(); // c6
    if_req = 1'b0;
    if (if_ack) acks++;
    tick();
    if (if_ack) acks++;
    n_cmp++; if (acks != 2) begin n_err++; $display("FAIL b2b_ack_count got=%0d exp=2", acks); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_simultaneous();
    test_slow_slave();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
